// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall/flush control, EX forwarding selects,
// data-memory wait tracking with timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StError   = 2'b10
  } state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mem_stall;
  logic       freeze;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs) begin
      return 2'b10;
    end else if (we_w && rd_w != 5'd0 && rd_w == rs) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign lu        = MemReadE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
  assign mem_stall = dmem_req && !dmem_ready;
  // A fresh miss in RUN freezes the pipe in the same cycle it is seen.
  assign freeze    = (state != StRun) || mem_stall;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StRun;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (StallF && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        StRun: begin
          if (mem_stall) begin
            state    <= StMemWait;
            wait_cnt <= 8'd1;
          end
        end
        StMemWait: begin
          // A dropped request counts as completion.
          if (!dmem_req || dmem_ready) begin
            state    <= StRun;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == MaxWait) begin
            state       <= StError;
            mem_timeout <= 1'b1;
          end else if (wait_cnt != 8'hff) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= StError;
      endcase
    end
  end

endmodule
